// File: rtl/mem_stage.sv
// Memory/writeback stage: one bus access per load/store, single-cycle writeback to the regfile.
// Optional MEM_STAGE_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of issuing them.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [1:0]  in_size,
  input  logic        in_signed,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  input  logic [3:0]  in_dest,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  write_addr,
  output logic [31:0] write_data,
  output logic        busy,
  output logic        fault
);
  typedef enum logic [0:0] {StIdle, StAccess} state_e;
  state_e state_q, state_d;

  logic        accept, is_mem, misalign, start, done, timeout_hit;
  logic [31:0] cnt_q, cnt_d;
  logic        ld_q, sgn_q;
  logic [1:0]  size_q, lane_q;
  logic [3:0]  dest_q;
  logic [3:0]  be_d, write_addr_d;
  logic [31:0] wdata_d, write_data_d, load_val;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic        fault_d;

  assign accept = in_valid & in_ready;
  assign is_mem = in_load | in_store;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misalign = is_mem & (((in_size == 2'd1) & in_addr[0]) |
                              (in_size[1] & (in_addr[1:0] != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign start       = accept & is_mem & ~misalign;
  assign done        = (state_q == StAccess) & bus_ack;
  // An ack in the final counted cycle takes priority over the timeout.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == StAccess) && !bus_ack &&
                       (cnt_q == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      StIdle:   if (start) state_d = StAccess;
      StAccess: begin
        cnt_d = bus_ack ? '0 : cnt_q + 32'd1;
        if (bus_ack || timeout_hit) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready = (state_q == StIdle);
    busy     = (state_q != StIdle);
    bus_req  = (state_q == StAccess);
  end

  always_comb begin
    case (in_size)
      2'd0: begin
        be_d    = 4'b0001 << in_addr[1:0];
        wdata_d = {4{in_store_data[7:0]}};
      end
      2'd1: begin
        be_d    = 4'b0011 << {in_addr[1], 1'b0};
        wdata_d = {2{in_store_data[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = in_store_data;
      end
    endcase
  end

  assign rd_byte = bus_rdata[{lane_q, 3'b000} +: 8];
  assign rd_half = bus_rdata[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'd0:    load_val = {{24{sgn_q & rd_byte[7]}}, rd_byte};
      2'd1:    load_val = {{16{sgn_q & rd_half[15]}}, rd_half};
      default: load_val = bus_rdata;
    endcase
  end

  always_comb begin
    write_addr_d = '0;
    write_data_d = '0;
    fault_d      = 1'b0;
    if (accept && !is_mem) begin
      write_addr_d = in_dest;
      write_data_d = (in_dest != 4'd0) ? in_addr : '0;
    end
    if (accept && misalign) fault_d = 1'b1;
    if (done && ld_q) begin
      write_addr_d = dest_q;
      write_data_d = (dest_q != 4'd0) ? load_val : '0;
    end
    if (timeout_hit) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      ld_q       <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= '0;
      lane_q     <= '0;
      dest_q     <= '0;
      write_addr <= '0;
      write_data <= '0;
      fault      <= 1'b0;
    end else begin
      if (start) begin
        bus_we    <= in_store & ~in_load;
        bus_addr  <= {in_addr[31:2], 2'b00};
        bus_be    <= be_d;
        bus_wdata <= wdata_d;
        ld_q      <= in_load;
        sgn_q     <= in_signed;
        size_q    <= in_size;
        lane_q    <= in_addr[1:0];
        dest_q    <= in_dest;
      end
      write_addr <= write_addr_d;
      write_data <= write_data_d;
      fault      <= fault_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a transaction-level model of the stage.
// Honours MEM_STAGE_MISALIGN_TRAP_EN the same way as the design.
module tb_mem_stage;
  localparam int unsigned TO = 4;

  logic        clk, rst_n;
  logic        in_valid, in_ready, in_load, in_store, in_signed;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_store_data;
  logic [3:0]  in_dest;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        busy, fault;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_dest(in_dest),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .write_addr(write_addr), .write_data(write_data), .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Expected writeback/fault for the current cycle and the next one.
  logic [3:0]  cur_wa, pend_wa;
  logic [31:0] cur_wd, pend_wd;
  logic        cur_flt, pend_flt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cur_wa = pend_wa; cur_wd = pend_wd; cur_flt = pend_flt;
    pend_wa = '0; pend_wd = '0; pend_flt = 1'b0;
  endtask

  task automatic check_wb(input string tag);
    @(negedge clk);
    check_eq({tag, "_wa"}, write_addr, cur_wa);
    check_eq({tag, "_wd"}, write_data, cur_wd);
    check_eq({tag, "_fault"}, fault, cur_flt);
  endtask

  function automatic logic m_misalign(input logic [1:0] sz, input logic [31:0] addr);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    if (sz == 2'd1) return (addr % 2) != 0;
    if (sz >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] addr, input logic [31:0] rd);
    int b[4];
    int v;
    int lane;
    for (int i = 0; i < 4; i++) b[i] = int'((rd >> (8 * i)) & 32'hff);
    if (sz == 2'd0) begin
      lane = int'(addr % 4);
      v = b[lane];
      if (sgn && v >= 128) v -= 256;
    end else if (sz == 2'd1) begin
      lane = int'((addr / 2) % 2);
      v = b[2 * lane] + 256 * b[2 * lane + 1];
      if (sgn && v >= 32768) v -= 65536;
    end else begin
      return rd;
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] addr);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      if (sz == 2'd0)      r[i] = (i == int'(addr % 4));
      else if (sz == 2'd1) r[i] = ((i / 2) == int'((addr / 2) % 2));
      else                 r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] sd);
    logic [31:0] r;
    int src;
    for (int i = 0; i < 4; i++) begin
      src = (sz == 2'd0) ? 0 : (sz == 2'd1) ? (i % 2) : i;
      r[8 * i +: 8] = sd[8 * src +: 8];
    end
    return r;
  endfunction

  // Issue one instruction and follow it until the stage is idle again.
  task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] sd, input logic [3:0] dest,
                        input int delay, input logic [31:0] rd);
    logic mem, trap;
    mem  = ld | st;
    trap = mem && m_misalign(sz, addr);
    in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_signed = sgn;
    in_addr = addr; in_store_data = sd; in_dest = dest; bus_ack = 1'b0;
    check_wb("accept");
    check_eq("in_ready_idle", in_ready, 1);
    check_eq("busy_idle", busy, 0);
    if (!mem) begin
      pend_wa = dest;
      pend_wd = (dest != 0) ? addr : 32'd0;
    end
    if (trap) pend_flt = 1'b1;
    tick();
    in_valid = 1'b0;
    in_addr = $urandom; in_store_data = $urandom; in_dest = 4'($urandom);
    if (!mem || trap) return;
    for (int k = 1; k <= int'(TO); k++) begin
      bus_ack   = (k == delay);
      bus_rdata = (k == delay) ? rd : $urandom;
      check_wb("access");
      check_eq("bus_req", bus_req, 1);
      check_eq("busy_acc", busy, 1);
      check_eq("in_ready_acc", in_ready, 0);
      check_eq("bus_addr", bus_addr, addr & 32'hffff_fffc);
      check_eq("bus_be", bus_be, m_be(sz, addr));
      check_eq("bus_we", bus_we, st && !ld);
      if (st && !ld) check_eq("bus_wdata", bus_wdata, m_wdata(sz, sd));
      if (k == delay) begin
        if (ld) begin
          pend_wa = dest;
          pend_wd = (dest != 0) ? m_load(sz, sgn, addr, rd) : 32'd0;
        end
        tick();
        bus_ack = 1'b0;
        return;
      end
      if (k == int'(TO)) pend_flt = 1'b1;
      tick();
    end
  endtask

  task automatic idle_cyc(input logic ack);
    in_valid = 1'b0; bus_ack = ack; bus_rdata = $urandom;
    check_wb("idle");
    check_eq("busy_idle_cyc", busy, 0);
    tick();
    bus_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = '0;
    in_signed = 1'b0; in_addr = '0; in_store_data = '0; in_dest = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    cur_wa = '0; cur_wd = '0; cur_flt = 1'b0; pend_wa = '0; pend_wd = '0; pend_flt = 1'b0;
    #2;
    check_eq("rst_bus_req", bus_req, 0);
    check_eq("rst_bus_we", bus_we, 0);
    check_eq("rst_bus_be", bus_be, 0);
    check_eq("rst_bus_addr", bus_addr, 0);
    check_eq("rst_bus_wdata", bus_wdata, 0);
    check_eq("rst_write_addr", write_addr, 0);
    check_eq("rst_write_data", write_data, 0);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed cases.
    run_op(0, 0, 2'd2, 0, 32'h1234, 32'h0, 4'd5, 0, 32'h0);
    run_op(0, 0, 2'd2, 0, 32'h55, 32'h0, 4'd6, 0, 32'h0);
    run_op(1, 0, 2'd0, 1, 32'h103, 32'h0, 4'd7, 3, 32'h80ff_1122);
    run_op(0, 1, 2'd1, 0, 32'h202, 32'habcd, 4'd9, 2, 32'h0);
    run_op(1, 0, 2'd2, 0, 32'h300, 32'h0, 4'd4, int'(TO) + 2, 32'h1111_2222);
    idle_cyc(1'b1);
    idle_cyc(1'b1);
    run_op(1, 0, 2'd1, 1, 32'h3fe, 32'h0, 4'd2, int'(TO), 32'h8001_7fff);
    run_op(1, 0, 2'd2, 0, 32'h3, 32'h0, 4'd8, 2, 32'hcafe_f00d);
    idle_cyc(1'b0);

    // Reset while a load is in flight.
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_size = 2'd2;
    in_addr = 32'h40; in_dest = 4'd3;
    check_wb("rst_seq");
    tick();
    in_valid = 1'b0;
    check_wb("rst_acc");
    check_eq("rst_acc_req", bus_req, 1);
    tick();
    rst_n = 1'b0;
    pend_wa = '0; pend_wd = '0; pend_flt = 1'b0;
    #1;
    check_eq("mid_rst_req", bus_req, 0);
    check_eq("mid_rst_wa", write_addr, 0);
    check_eq("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus_ack = 1'b1; bus_rdata = 32'hdead_beef;
    check_wb("post_rst");
    check_eq("post_rst_ready", in_ready, 1);
    tick();
    bus_ack = 1'b0;
    check_wb("post_rst_ack");
    tick();

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int kind;
      logic ld, st;
      logic [31:0] a;
      kind = int'($urandom_range(0, 3));
      ld = (kind == 1) || (kind == 3);
      st = (kind == 2) || (kind == 3);
      a  = $urandom;
      run_op(ld, st, 2'($urandom), 1'($urandom), a, $urandom, 4'($urandom),
             int'($urandom_range(1, TO + 2)), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cyc(1'($urandom));
    end
    idle_cyc(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory/writeback pipeline stage directly upstream of the register file.
- Accepts one executed instruction per handshake: ALU result, destination register, load/store control.
- Performs the data-bus access with a req/ack handshake, aligns and extends load data, and drives the register file's writeback port (write_addr/write_data) for exactly one cycle per completed instruction.
- Also flags busy so the front end stalls while a bus access is in flight.

Parameters:
- TIMEOUT, 255, bus cycles to wait for bus_ack before aborting. 0 disables the timeout.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; transfer when in_valid & in_ready
- in_load  in  1  instruction is a load
- in_store  in  1  instruction is a store (in_load & in_store is treated as a load)
- in_size  in  2  0=byte, 1=half, 2=word, 3=word
- in_signed  in  1  sign-extend sub-word loads
- in_addr  in  32  ALU result; memory address or writeback value
- in_store_data  in  32  store value, in the low bits
- in_dest  in  4  destination register; 0 = no writeback
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  write request
- bus_addr  out  32  word-aligned address ({in_addr[31:2],2'b00})
- bus_be  out  4  byte enables
- bus_wdata  out  32  store data replicated into lanes
- bus_ack  in  1  single-cycle completion of the current request
- bus_rdata  in  32  read data, valid with bus_ack
- write_addr  out  4  register file writeback address
- write_data  out  32  register file writeback data
- busy  out  1  access in flight (state != IDLE)
- fault  out  1  one-cycle pulse on timeout or misaligned trap

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; bus_req=0; bus_we=0; bus_be=0; bus_addr=0; bus_wdata=0; write_addr=0; write_data=0; fault=0; timeout counter=0. Reset mid-access drops bus_req immediately; a later bus_ack is ignored.
- States:
  - IDLE: in_ready=1.
  - ACCESS: in_ready=0; bus_req=1; bus signals stable.
  - ACCESS→IDLE on bus_ack or on timeout.
- Non-memory instruction accepted in cycle N: write_addr=in_dest and write_data=in_addr during cycle N+1 only. Stays IDLE, so back-to-back accepts give one writeback per cycle.
- Load/store accepted in cycle N: enters ACCESS; bus_req high from cycle N+1.
- Completion: bus_ack in cycle M completes the access.
  - Load: write_addr=dest, write_data=extended data during M+1.
  - Store: write_addr=0 during M+1.
  - State is IDLE in M+1, so a new instruction can be accepted in M+1.
- write_addr is 0 in every cycle without a writeback. write_data is don't-care when write_addr=0; drive 0.
- Lanes: byte lane = addr[1:0]; half lane = addr[1].
  - bus_be: byte = 1<<addr[1:0]; half = 4'b0011<<{addr[1],1'b0}; word = 4'b1111.
  - bus_wdata: byte data replicated ×4; half data replicated ×2; word unchanged.
- Load extraction:
  - Select lane from bus_rdata.
  - Zero-extend, or sign-extend from bit 7/15 when in_signed.
  - Word loads ignore in_signed.
- Timeout:
  - Counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - On reaching TIMEOUT: return to IDLE, fault pulses 1 cycle, no writeback.
  - bus_ack in the same cycle as the timeout wins: normal completion, no fault.
- bus_ack while in IDLE is ignored.

Optional Feature:
- MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - Half with addr[0]=1, or word with addr[1:0]!=0, issues no bus access and stays IDLE.
  - fault pulses in N+1 and write_addr=0.
- Undefined:
  - Misaligned low bits are ignored. Half uses lane addr[1]; word uses lane 0 with bus_be=4'b1111.
  - fault only from timeout.

Test Plan:
- ALU op, in_dest=5, in_addr=0x1234 accepted back-to-back with dest=6, addr=0x55 → write_addr=5/write_data=0x1234 then 6/0x55 on consecutive cycles; busy stays 0.
- Load byte signed, addr=0x103, bus_rdata=0x80FF_1122, ack after 3 cycles → bus_addr=0x100, bus_be=4'b1000, bus_req held 3 cycles; write_addr=dest, write_data=0xFFFF_FF80 one cycle after ack.
- Store half, addr=0x202, data=0xABCD → bus_we=1, bus_be=4'b1100, bus_wdata=0xABCD_ABCD; write_addr=0 after ack.
- TIMEOUT=4, load with no ack → bus_req high 4 cycles, then IDLE, fault pulse, no writeback; late ack ignored.
- rst_n low while bus_req high → bus_req=0 immediately, write_addr=0, in_ready=1 after release.
- Word load at addr=0x3: with MEM_STAGE_MISALIGN_TRAP_EN → no bus_req, fault=1; without it → bus_addr=0x0, bus_be=4'b1111, normal writeback.
